// File: rtl/fetch_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset PC, bubble word, fetch entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc4;
    } fetch_ent_t;

    // J/JAL target: region bits come from the jump's own PC+4.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding an instruction word and its PC+4.
// Latency: word visible the cycle after load.
// Backpressure: full blocks new fetch requests upstream; clear beats load.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       load,
    input  logic       drain,
    input  fetch_ent_t load_ent,
    output logic       full,
    output fetch_ent_t ent
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full <= 1'b0;
            ent  <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            ent  <= load_ent;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: single-outstanding imem requests, redirect handling, skid buffer.
// Latency: word reaches FetchData_IF on the edge after ImemValid (or first unstalled edge).
// Backpressure: AnyStall holds outputs; a full skid entry stops new requests.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        AnyStall,
    input  logic        Jump_ID,
    input  logic [25:0] JumpTgt_ID,
    input  logic        BranchTaken_EX,
    input  logic [31:0] BranchTgt_EX,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    output logic [31:0] FetchData_IF,
    output logic [31:0] PcPlus4_IF
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic         redirect;
    logic [31:0]  redirect_tgt;
    logic         req;
    logic         accept;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_clear;
    logic         skid_full;
    fetch_ent_t   skid_ent;

    always_comb begin
        redirect     = BranchTaken_EX || (Jump_ID && !AnyStall);
        redirect_tgt = BranchTaken_EX ? BranchTgt_EX : jump_target(PcPlus4_IF, JumpTgt_ID);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request issued in the same cycle as a redirect fetches a stale PC, so it is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = redirect ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (ImemValid)     state_nxt = ST_IDLE;
                else if (redirect) state_nxt = ST_DROP;
            end
            ST_DROP: if (ImemValid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req        = reset_n && (state == ST_IDLE) && !skid_full;
        accept     = (state == ST_WAIT) && ImemValid && !redirect && !flush;
        skid_load  = accept && AnyStall;
        skid_drain = skid_full && !AnyStall;
        skid_clear = flush || redirect;
        ImemReq    = req;
        ImemAddr   = {pc[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= {RESET_PC[31:2], 2'b00};
            req_addr <= {RESET_PC[31:2], 2'b00};
        end else begin
            if (redirect) begin
                pc <= {redirect_tgt[31:2], 2'b00};
            end else if (req) begin
                pc <= pc + 32'd4;
            end
            if (req) begin
                req_addr <= pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            FetchData_IF <= NOP_WORD;
            PcPlus4_IF   <= 32'h0;
        end else if (flush) begin
            FetchData_IF <= NOP_WORD;
        end else if (!AnyStall) begin
            if (redirect) begin
                FetchData_IF <= NOP_WORD;
            end else if (skid_full) begin
                FetchData_IF <= skid_ent.word;
                PcPlus4_IF   <= skid_ent.pc4;
            end else if (accept) begin
                FetchData_IF <= ImemData;
                PcPlus4_IF   <= req_addr + 32'd4;
            end else begin
                FetchData_IF <= NOP_WORD;
            end
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (skid_clear),
        .load     (skid_load),
        .drain    (skid_drain),
        .load_ent ('{word: ImemData, pc4: req_addr + 32'd4}),
        .full     (skid_full),
        .ent      (skid_ent)
    );

endmodule

// File: tb/tb_fetch.sv
// Scoreboarded bench for fetch: memory model plus request/word monitors.
module tb_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, flush, AnyStall, Jump_ID, BranchTaken_EX;
    logic [25:0] JumpTgt_ID;
    logic [31:0] BranchTgt_EX;
    logic        ImemReq, ImemValid;
    logic [31:0] ImemAddr, ImemData, FetchData_IF, PcPlus4_IF;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mem_lat = 1;
    logic [31:0] exp_addr_q[$];
    fetch_ent_t  exp_word_q[$];

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .AnyStall       (AnyStall),
        .Jump_ID        (Jump_ID),
        .JumpTgt_ID     (JumpTgt_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .BranchTgt_EX   (BranchTgt_EX),
        .ImemReq        (ImemReq),
        .ImemAddr       (ImemAddr),
        .ImemValid      (ImemValid),
        .ImemData       (ImemData),
        .FetchData_IF   (FetchData_IF),
        .PcPlus4_IF     (PcPlus4_IF)
    );

    function automatic logic [31:0] wfun(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] a);
        fetch_ent_t e;
        e.word = wfun(a);
        e.pc4  = a + 32'd4;
        exp_word_q.push_back(e);
    endtask

    task automatic phase_end(input string name);
        check({name, "_addrs_left"}, 32'(exp_addr_q.size()), 32'd0);
        check({name, "_words_left"}, 32'(exp_word_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int lat);
        reset_n        = 1'b0;
        flush          = 1'b0;
        AnyStall       = 1'b0;
        Jump_ID        = 1'b0;
        JumpTgt_ID     = '0;
        BranchTaken_EX = 1'b0;
        BranchTgt_EX   = '0;
        mem_lat        = lat;
        tick();
        @(negedge clk);
        check("rst_fetch_data", FetchData_IF, 32'h0);
        check("rst_pc_plus4", PcPlus4_IF, 32'h0);
        check("rst_imem_req", 32'(ImemReq), 32'd0);
        repeat (4) tick();
        exp_addr_q.delete();
        exp_word_q.delete();
        reset_n = 1'b1;
    endtask

    // Memory model: one response per request after mem_lat cycles; checks each request address.
    initial begin
        logic [31:0] a;
        ImemValid = 1'b0;
        ImemData  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (ImemReq === 1'b1) begin
                a = ImemAddr;
                if (exp_addr_q.size() > 0) check("imem_addr", a, exp_addr_q.pop_front());
                @(posedge clk);
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                ImemValid = 1'b1;
                ImemData  = wfun(a);
                @(posedge clk);
                #1;
                ImemValid = 1'b0;
                ImemData  = 32'hDEAD_BEEF;
            end
        end
    end

    // Word monitor: every newly presented non-bubble word is checked against the scoreboard.
    initial begin
        logic [31:0] prev;
        fetch_ent_t  e;
        prev = 32'h0;
        forever begin
            @(negedge clk);
            if (FetchData_IF !== prev && FetchData_IF !== 32'h0 && exp_word_q.size() > 0) begin
                e = exp_word_q.pop_front();
                check("fetch_word", FetchData_IF, e.word);
                check("fetch_pc4", PcPlus4_IF, e.pc4);
            end
            prev = FetchData_IF;
        end
    end

    task automatic redirect_phase(input string name, input logic br, input logic [31:0] btgt,
                                  input logic jmp, input logic [25:0] jidx,
                                  input logic [31:0] tgt);
        do_reset(3);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(tgt);
        push_word(tgt);
        repeat (2) tick();
        BranchTaken_EX = br;
        BranchTgt_EX   = btgt;
        Jump_ID        = jmp;
        JumpTgt_ID     = jidx;
        tick();
        BranchTaken_EX = 1'b0;
        Jump_ID        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check({name, "_bubble"}, FetchData_IF, 32'h0);
            tick();
        end
        @(negedge clk);
        check({name, "_target_word"}, FetchData_IF, wfun(tgt));
        repeat (4) tick();
        phase_end(name);
    endtask

    initial begin
        reset_n = 1'b0;

        // Sequential fetch, latency 1.
        do_reset(1);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_word(32'h0);
        push_word(32'h4);
        push_word(32'h8);
        @(negedge clk);
        check("first_req", 32'(ImemReq), 32'd1);
        repeat (10) tick();
        phase_end("seq");

        // Stall while a response arrives: word goes to the skid entry.
        do_reset(1);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_word(32'h0);
        push_word(32'h4);
        push_word(32'h8);
        repeat (2) tick();
        AnyStall = 1'b1;
        tick();
        @(negedge clk);
        check("stall_hold_c3", FetchData_IF, wfun(32'h0));
        tick();
        @(negedge clk);
        check("stall_hold_c4", FetchData_IF, wfun(32'h0));
        check("stall_noreq_c4", 32'(ImemReq), 32'd0);
        tick();
        AnyStall = 1'b0;
        @(negedge clk);
        check("stall_hold_c5", FetchData_IF, wfun(32'h0));
        check("stall_noreq_c5", 32'(ImemReq), 32'd0);
        tick();
        @(negedge clk);
        check("skid_drain_word", FetchData_IF, wfun(32'h4));
        check("skid_drain_pc4", PcPlus4_IF, 32'h8);
        check("post_drain_req", 32'(ImemReq), 32'd1);
        repeat (6) tick();
        phase_end("stall");

        // Redirects during WAIT, latency 3.
        redirect_phase("branch", 1'b1, 32'h0000_0100, 1'b0, 26'h0, 32'h0000_0100);
        redirect_phase("br_over_jmp", 1'b1, 32'h0000_0200, 1'b1, 26'h40, 32'h0000_0200);
        redirect_phase("jump", 1'b0, 32'h0, 1'b1, 26'h40, 32'h0000_0100);

        // Flush with stall and a full skid entry.
        do_reset(1);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_word(32'h0);
        push_word(32'h8);
        repeat (2) tick();
        AnyStall = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("flush_pre_hold", FetchData_IF, wfun(32'h0));
        tick();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        AnyStall = 1'b0;
        @(negedge clk);
        check("flush_data", FetchData_IF, 32'h0);
        check("flush_skid_empty_req", 32'(ImemReq), 32'd1);
        repeat (6) tick();
        phase_end("flush");

        // Reset while a request is outstanding; the late response lands during reset.
        do_reset(3);
        exp_addr_q.push_back(32'h0);
        tick();
        do_reset(3);
        exp_addr_q.push_back(32'h0);
        push_word(32'h0);
        @(negedge clk);
        check("post_rst_req", 32'(ImemReq), 32'd1);
        tick();
        @(negedge clk);
        check("late_resp_ignored", FetchData_IF, 32'h0);
        repeat (8) tick();
        phase_end("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
